// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and sequencer that shares the single data-memory port
// between the load/store unit (m0) and a second bus master (m1).
module dmem_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_cs,
    input  logic        m0_wr,
    input  logic [3:0]  m0_mask,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_valid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_cs,
    input  logic        m1_wr,
    input  logic [3:0]  m1_mask,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_valid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic        cs,
    output logic        wr,
    output logic [3:0]  mask,
    output logic [31:0] addr,
    output logic [31:0] data_wr,
    input  logic        valid_DM,
    input  logic [31:0] data_rd,
    output logic        busy
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_e;

    state_e        state_q, state_d;
    logic          gnt_q, gnt_d;
    logic          last_gnt_q, last_gnt_d;
    logic          wr_q, wr_d;
    logic [3:0]    mask_q, mask_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        wr_d       = wr_q;
        mask_d     = mask_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        tcnt_d     = tcnt_q;
        rdata_d    = rdata_q;
        err_d      = err_q;

        case (state_q)
            IDLE: begin
                if (m0_cs || m1_cs) begin
                    // On a tie the requester that did not win last time gets the port.
                    gnt_d      = (m0_cs && m1_cs) ? ~last_gnt_q : m1_cs;
                    last_gnt_d = gnt_d;
                    wr_d       = gnt_d ? m1_wr    : m0_wr;
                    mask_d     = gnt_d ? m1_mask  : m0_mask;
                    addr_d     = gnt_d ? m1_addr  : m0_addr;
                    wdata_d    = gnt_d ? m1_wdata : m0_wdata;
                    tcnt_d     = '0;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                if (valid_DM) begin
                    rdata_d = wr_q ? 32'd0 : data_rd;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (tcnt_q == TLAST) begin
                    rdata_d = 32'd0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= 1'b0;
            last_gnt_q <= 1'b1;
            wr_q       <= 1'b0;
            mask_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            tcnt_q     <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            wr_q       <= wr_d;
            mask_q     <= mask_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            tcnt_q     <= tcnt_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    logic in_busy;
    logic in_resp;

    assign in_busy = (state_q == BUSY);
    assign in_resp = (state_q == RESP);

    // Memory command is only presented in BUSY so the port idles at all-zero.
    assign cs      = in_busy;
    assign wr      = in_busy & wr_q;
    assign mask    = in_busy ? mask_q  : 4'd0;
    assign addr    = in_busy ? addr_q  : 32'd0;
    assign data_wr = in_busy ? wdata_q : 32'd0;
    assign busy    = (state_q != IDLE);

    assign m0_valid = in_resp & ~gnt_q;
    assign m1_valid = in_resp &  gnt_q;
    assign m0_rdata = m0_valid ? rdata_q : 32'd0;
    assign m1_rdata = m1_valid ? rdata_q : 32'd0;
    assign m0_err   = m0_valid & err_q;
    assign m1_err   = m1_valid & err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios followed by random
// accesses, all predicted by a transaction-level model of grant order and timing.
module tb_dmem_arbiter;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_cs, m0_wr, m1_cs, m1_wr;
    logic [3:0]  m0_mask, m1_mask;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_valid, m0_err, m1_valid, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        cs, wr, busy, valid_DM;
    logic [3:0]  mask;
    logic [31:0] addr, data_wr, data_rd;

    int checks = 0;
    int errors = 0;
    int lastWinner = 1;

    dmem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .m0_cs(m0_cs), .m0_wr(m0_wr), .m0_mask(m0_mask), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_valid(m0_valid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_cs(m1_cs), .m1_wr(m1_wr), .m1_mask(m1_mask), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_valid(m1_valid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .cs(cs), .wr(wr), .mask(mask), .addr(addr), .data_wr(data_wr),
        .valid_DM(valid_DM), .data_rd(data_rd), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkQuiet(input string tag);
        checkOutput({tag, "_cs"}, 32'(cs), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_valids"}, 32'({m0_valid, m1_valid}), 32'd0);
        checkOutput({tag, "_addr"}, addr, 32'd0);
    endtask

    // One complete access starting from IDLE with requests already driven.
    // lat = BUSY cycle (1-based) in which memory answers; 0 means never.
    task automatic applyStimulus(input int lat, input bit perturb);
        int          winner, n;
        bit          timedOut;
        logic        expWr;
        logic [3:0]  expMask;
        logic [31:0] expAddr, expWdata, memData, expRdata;

        if (m0_cs && m1_cs) winner = 1 - lastWinner;
        else                winner = m1_cs ? 1 : 0;
        lastWinner = winner;
        expWr    = winner ? m1_wr    : m0_wr;
        expMask  = winner ? m1_mask  : m0_mask;
        expAddr  = winner ? m1_addr  : m0_addr;
        expWdata = winner ? m1_wdata : m0_wdata;
        memData  = $urandom;
        timedOut = (lat == 0) || (lat > TIMEOUT);
        n        = timedOut ? TIMEOUT : lat;
        expRdata = (timedOut || expWr) ? 32'd0 : memData;

        tick();
        for (int j = 1; j <= n; j++) begin
            checkOutput("busy_cs", 32'(cs), 32'd1);
            checkOutput("busy_flag", 32'(busy), 32'd1);
            checkOutput("cmd_addr", addr, expAddr);
            checkOutput("cmd_wr", 32'(wr), 32'(expWr));
            checkOutput("cmd_mask", 32'(mask), 32'(expMask));
            checkOutput("cmd_wdata", data_wr, expWdata);
            checkOutput("busy_no_pulse", 32'({m0_valid, m1_valid}), 32'd0);
            if (perturb) begin
                m0_addr  = $urandom;
                m1_addr  = $urandom;
                m0_wdata = $urandom;
                m1_mask  = 4'($urandom);
                m0_wr    = ~m0_wr;
            end
            valid_DM = (j == lat);
            data_rd  = (j == lat) ? memData : $urandom;
            tick();
        end

        valid_DM = 1'($urandom_range(0, 1));
        data_rd  = $urandom;
        checkOutput("resp_cs", 32'(cs), 32'd0);
        checkOutput("resp_busy", 32'(busy), 32'd1);
        if (winner == 0) begin
            checkOutput("m0_valid", 32'(m0_valid), 32'd1);
            checkOutput("m0_rdata", m0_rdata, expRdata);
            checkOutput("m0_err", 32'(m0_err), 32'(timedOut));
            checkOutput("m1_quiet", {m1_rdata[31:2], m1_valid, m1_err}, 32'd0);
        end else begin
            checkOutput("m1_valid", 32'(m1_valid), 32'd1);
            checkOutput("m1_rdata", m1_rdata, expRdata);
            checkOutput("m1_err", 32'(m1_err), 32'(timedOut));
            checkOutput("m0_quiet", {m0_rdata[31:2], m0_valid, m0_err}, 32'd0);
        end
        tick();
        valid_DM = 1'b0;
        checkQuiet("idle");
    endtask

    task automatic setReq(input int who, input logic wrV, input logic [3:0] maskV,
                          input logic [31:0] addrV, input logic [31:0] wdataV);
        if (who == 0) begin
            m0_cs = 1'b1; m0_wr = wrV; m0_mask = maskV; m0_addr = addrV; m0_wdata = wdataV;
        end else begin
            m1_cs = 1'b1; m1_wr = wrV; m1_mask = maskV; m1_addr = addrV; m1_wdata = wdataV;
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        lastWinner = 1;
    endtask

    initial begin
        int pick, lat;
        rst = 1'b1;
        m0_cs = 1'b1; m0_wr = 1'b0; m0_mask = 4'hF; m0_addr = 32'h4; m0_wdata = 32'h0;
        m1_cs = 1'b1; m1_wr = 1'b1; m1_mask = 4'hF; m1_addr = 32'h8; m1_wdata = 32'h0;
        valid_DM = 1'b1; data_rd = 32'hFFFF_FFFF;

        tick();
        tick();
        checkQuiet("reset");
        checkOutput("reset_rdata", m0_rdata | m1_rdata, 32'd0);
        checkOutput("reset_cmd", {data_wr[31:6], wr, m0_err, m1_err, mask}, 32'd0);
        m0_cs = 1'b0; m1_cs = 1'b0; valid_DM = 1'b0;
        rst = 1'b0;
        lastWinner = 1;
        tick();
        checkQuiet("post_reset");

        // m0 load answered in the first BUSY cycle
        data_rd = 32'hDEAD_BEEF;
        setReq(0, 1'b0, 4'hF, 32'h10, 32'h0);
        applyStimulus(1, 1'b0);
        m0_cs = 1'b0;

        // m1 store answered after three BUSY cycles
        setReq(1, 1'b1, 4'b0011, 32'h20, 32'h1122_3344);
        applyStimulus(3, 1'b0);
        m1_cs = 1'b0;

        // both held from reset: grants alternate starting with m0
        doReset();
        setReq(0, 1'b0, 4'hF, 32'h100, 32'h0);
        setReq(1, 1'b0, 4'hF, 32'h200, 32'h0);
        for (int i = 0; i < 4; i++) applyStimulus(1, 1'b0);
        m0_cs = 1'b0; m1_cs = 1'b0;

        // memory never answers, then a normal access
        setReq(0, 1'b0, 4'hF, 32'h44, 32'h0);
        applyStimulus(0, 1'b0);
        m0_cs = 1'b0;
        setReq(1, 1'b0, 4'hF, 32'h48, 32'h0);
        applyStimulus(2, 1'b0);
        m1_cs = 1'b0;

        // reset in the second BUSY cycle of an m0 load
        setReq(0, 1'b0, 4'hF, 32'h40, 32'h0);
        tick();
        tick();
        checkOutput("pre_rst_cs", 32'(cs), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        lastWinner = 1;
        checkQuiet("rst_abort");
        applyStimulus(2, 1'b0);
        m0_cs = 1'b0;

        // requester changes command in BUSY, stray valid_DM in IDLE
        setReq(0, 1'b0, 4'hF, 32'h10, 32'h0);
        applyStimulus(2, 1'b1);
        m0_cs = 1'b0;
        valid_DM = 1'b1;
        data_rd = 32'hBAD0_BAD0;
        tick();
        valid_DM = 1'b0;
        checkQuiet("stray_valid");

        for (int i = 0; i < 30; i++) begin
            m0_cs = 1'($urandom_range(0, 1));
            m1_cs = 1'($urandom_range(0, 1));
            if (!m0_cs && !m1_cs) m0_cs = 1'b1;
            m0_wr = 1'($urandom); m0_mask = 4'($urandom); m0_addr = $urandom; m0_wdata = $urandom;
            m1_wr = 1'($urandom); m1_mask = 4'($urandom); m1_addr = $urandom; m1_wdata = $urandom;
            pick = $urandom_range(0, 9);
            lat = (pick < 7) ? pick + 1 : (pick == 7) ? 0 : (pick == 8) ? TIMEOUT : TIMEOUT + 3;
            applyStimulus(lat, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) begin
                m0_cs = 1'b0; m1_cs = 1'b0;
                valid_DM = 1'($urandom_range(0, 1));
                tick();
                valid_DM = 1'b0;
                checkQuiet("rand_gap");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and sequencer for the single data-memory port. It sits between the load/store unit (requester 0) and a second bus master (requester 1: debug loader / DMA), and the Data_Memory cs/wr/mask/addr/data_wr/valid_DM port. It grants one request at a time with round-robin fairness, holds the memory command until the memory signals valid, and returns a one-cycle response to the granted requester. A timeout counter guarantees every granted request terminates.

## Interface
- TIMEOUT, 16, number of BUSY cycles without valid_DM before the access is aborted with error (≥1)
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset; synchronous, active-high
- m0_cs, m1_cs  in  1 each  request; held high with command stable until that requester's valid pulse
- m0_wr, m1_wr  in  1 each  1 = store, 0 = load
- m0_mask, m1_mask  in  4 each  byte-lane write mask
- m0_addr, m1_addr  in  32 each  byte address
- m0_wdata, m1_wdata  in  32 each  store data
- m0_valid, m1_valid  out  1 each  one-cycle response pulse
- m0_rdata, m1_rdata  out  32 each  load data, valid with the pulse
- m0_err, m1_err  out  1 each  timeout flag, valid with the pulse
- cs, wr  out  1 each  memory command
- mask  out  4  memory byte mask
- addr, data_wr  out  32 each  memory address / store data
- valid_DM  in  1  memory completion, may assert in the same cycle cs is first high
- data_rd  in  32  memory load data, valid with valid_DM
- busy  out  1  high in BUSY and RESP

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: if any mX_cs is high, pick a winner, register its wr/mask/addr/wdata into the command register, record gnt, and go to BUSY. Otherwise stay in IDLE.
- Arbitration: a single requester always wins. If both request, the winner is the requester not granted last (last_gnt register). last_gnt resets to 1, so m0 wins the first tie. last_gnt updates only on a grant.
- BUSY: cs=1 and wr/mask/addr/data_wr are driven from the command register. Requester inputs are ignored, so changes to them have no effect.
  - On valid_DM=1: capture data_rd into the response register (captured for loads; stores capture 0), clear err, and go to RESP.
  - Otherwise increment tcnt. When tcnt reaches TIMEOUT-1 and valid_DM=0, set err=1, set the response data to 0, and go to RESP.
- RESP: cs=0. The granted mX_valid=1 for exactly this cycle, with mX_rdata and mX_err from the response register. The non-granted requester sees valid=0, rdata=0, err=0. Next state is IDLE.
- tcnt: $clog2(TIMEOUT) bits wide. Cleared on entry to BUSY and never wraps within an access.
- The requester samples valid at the end of RESP and must drop cs or present a new command by the following IDLE cycle. A cs still high in IDLE is treated as a new request.
- A late valid_DM arriving in IDLE or RESP is ignored.
- Reset (any state):
  - Next state is IDLE. cs, wr, mask, addr, data_wr, every mX_valid, mX_err, mX_rdata, and busy all read 0. last_gnt=1, tcnt=0.
  - An in-flight access gets no response pulse. A requester holding cs is re-arbitrated after reset.

## Timing
- Outputs are registered or decoded from state only. There is no combinational path from mX_cs or valid_DM to any output.
- A request seen in IDLE at cycle t drives memory cs in t+1.
- With valid_DM in cycle t+k (k≥1), RESP (valid pulse) falls in cycle t+k+1 and IDLE in t+k+2.
- Minimum access: 3 cycles (IDLE, BUSY, RESP). Peak throughput is one access per 3 cycles.
- Timeout: valid_DM never arrives → BUSY lasts exactly TIMEOUT cycles, then a RESP pulse with err=1.
- Back-to-back with both requesters held high: grants alternate m0, m1, m0, …, one grant per IDLE.

## Test plan
- Reset then m0 load addr 0x10, memory returns 0xDEADBEEF with valid_DM in the first BUSY cycle → cs high for 1 cycle; m0_valid=1 with rdata 0xDEADBEEF and err=0 exactly 2 cycles after request sampling; m1_valid stays 0.
- m1 store addr 0x20, wdata 0x11223344, mask 4'b0011, memory valid after 3 BUSY cycles → addr/data_wr/mask stable for 3 cycles; m1_valid pulses once with rdata 0.
- Both cs high from reset, held for 4 accesses, memory valid in the first BUSY cycle → grant order m0, m1, m0, m1; a valid pulse every 3 cycles.
- Memory never asserts valid_DM, TIMEOUT=16 → cs high for exactly 16 cycles; then a pulse with err=1 and rdata 0; the next request completes normally.
- rst asserted in the second BUSY cycle of an m0 load → next cycle cs=0, busy=0, no m0_valid; m0_cs still high → re-granted and completes after rst drops.
- m0 changes addr in BUSY (0x10→0x30) and valid_DM arrives in IDLE → memory addr stays 0x10; the stray valid_DM produces no pulse.
